// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-memory load/fetch arbiter.
// State encoding plus instruction constants.
package imem_load_arbiter_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          INST_BYTES = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs loader bytes little-endian into 32-bit words; one-cycle registered write strobe.
// Latency: word write issued the cycle after its lane-3 byte (or after ld_done for a partial word).
module imem_byte_packer
    import imem_load_arbiter_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        xfer,
    input  logic        done,
    input  logic [7:0]  ld_byte,
    output logic        partial,
    output logic        word_we,
    output logic [63:0] word_addr,
    output logic [31:0] word_data,
    output logic        overflow
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_d;
    logic [31:0]      asm_q;
    logic [31:0]      asm_d;
    logic             in_range;
    logic             take;
    logic             we_d;

    always_comb begin
        in_range = wr_ptr < PTR_W'(DEPTH);
        take     = xfer && in_range;
        asm_d    = asm_q;
        ptr_d    = wr_ptr;
        if (take) begin
            asm_d[{wr_ptr[1:0], 3'b000} +: 8] = ld_byte;
            ptr_d = wr_ptr + PTR_W'(1);
        end
        partial = ptr_d[1:0] != 2'b00;
        // Missing lanes of a partial word are already zero: asm_q is cleared after every write.
        we_d    = (take && wr_ptr[1:0] == 2'd3) || (done && partial);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            asm_q     <= '0;
            word_we   <= 1'b0;
            word_addr <= '0;
            word_data <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            asm_q    <= '0;
            word_we  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr  <= ptr_d;
            asm_q   <= we_d ? 32'h0 : asm_d;
            word_we <= we_d;
            if (we_d) begin
                word_addr <= {{(64 - PTR_W){1'b0}}, wr_ptr[PTR_W-1:2], 2'b00};
                word_data <= asm_d;
            end
            if (xfer && !in_range) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction-memory port between the byte loader and the IF stage.
// Fetch latency 1 cycle; loader throttled only by ld_ready (high throughout S_LOAD).
module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int DEPTH         = 128,
    parameter bit LOAD_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    input  logic        ld_done,
    input  logic        load_start,
    input  logic        fetch_req,
    input  logic [63:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic        fetch_fault,
    output logic        cpu_run,
    output logic        ld_overflow,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam state_t RST_STATE = LOAD_ON_RESET ? S_LOAD : S_RUN;

    state_t      state;
    logic        in_load;
    logic        in_run;
    logic        pk_partial;
    logic        pk_we;
    logic [63:0] pk_addr;
    logic        bad_addr;

    assign in_load  = state == S_LOAD;
    assign in_run   = state == S_RUN;
    assign bad_addr = (fetch_addr[1:0] != 2'b00) || (fetch_addr > 64'(DEPTH - INST_BYTES));

    imem_byte_packer #(.DEPTH(DEPTH)) u_packer (
        .clk       (clk),
        .rst       (reset),
        .clr       (in_run && load_start),
        .xfer      (in_load && ld_valid),
        .done      (in_load && ld_done),
        .ld_byte   (ld_byte),
        .partial   (pk_partial),
        .word_we   (pk_we),
        .word_addr (pk_addr),
        .word_data (mem_wdata),
        .overflow  (ld_overflow)
    );

    // A final word still draining in the first run cycle keeps the port.
    assign mem_we   = pk_we;
    assign mem_addr = (!pk_we && in_run && fetch_req) ? fetch_addr : pk_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RST_STATE;
            ld_ready    <= LOAD_ON_RESET;
            cpu_run     <= !LOAD_ON_RESET;
            fetch_valid <= 1'b0;
            fetch_inst  <= NOP_INST;
            fetch_fault <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (ld_done) begin
                        ld_ready <= 1'b0;
                        if (pk_partial) begin
                            state <= S_FLUSH;
                        end else begin
                            state   <= S_RUN;
                            cpu_run <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    state   <= S_RUN;
                    cpu_run <= 1'b1;
                end
                S_RUN: begin
                    if (load_start) begin
                        state    <= S_LOAD;
                        ld_ready <= 1'b1;
                        cpu_run  <= 1'b0;
                    end else if (fetch_req) begin
                        fetch_valid <= 1'b1;
                        fetch_fault <= bad_addr;
                        fetch_inst  <= bad_addr ? NOP_INST : mem_rdata;
                    end
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench: expected writes/fetch results queued by stimulus, popped by a negedge monitor.
module tb_imem_load_arbiter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_done;
    logic        load_start;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        fetch_fault;
    logic        cpu_run;
    logic        ld_overflow;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_load_arbiter #(.DEPTH(DEPTH), .LOAD_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(rst),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_done(ld_done),
        .load_start(load_start),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_fault(fetch_fault),
        .cpu_run(cpu_run), .ld_overflow(ld_overflow),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory array behind the DUT port.
    logic [7:0] mem [DEPTH];
    int ra;
    always @(posedge clk) begin
        if (mem_we && mem_addr <= 64'(DEPTH - 4)) begin
            for (int i = 0; i < 4; i++) mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
        end
    end
    always_comb begin
        ra = int'(mem_addr[7:0]);
        mem_rdata = 32'hDEAD_BEEF;
        if (mem_addr <= 64'(DEPTH - 4)) mem_rdata = {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
    end

    typedef struct { logic [63:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] inst; logic fault; } fe_t;
    wr_t wq[$];
    fe_t fq[$];
    wr_t mw;
    fe_t mf;
    logic [7:0] bq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wq.size() == 0) unexpected("unexpected_write", mem_addr);
                else begin
                    mw = wq.pop_front();
                    chk("wr_addr", mem_addr, mw.addr);
                    chk("wr_data", 64'(mem_wdata), 64'(mw.data));
                end
            end
            if (fetch_valid) begin
                if (fq.size() == 0) unexpected("unexpected_fetch", 64'(fetch_inst));
                else begin
                    mf = fq.pop_front();
                    chk("fetch_inst", 64'(fetch_inst), 64'(mf.inst));
                    chk("fetch_fault", 64'(fetch_fault), 64'(mf.fault));
                end
            end
        end
    end

    task automatic push_wr(input logic [63:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic stream(input bit done);
        for (int i = 0; i < bq.size(); i++) begin
            ld_valid = 1'b1;
            ld_byte  = bq[i];
            ld_done  = done && (i == bq.size() - 1);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input logic [31:0] inst, input logic fault);
        fe_t f;
        f.inst  = inst;
        f.fault = fault;
        fq.push_back(f);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ld_ready"}, 64'(ld_ready), 64'd1);
        chk({tag, "_cpu_run"}, 64'(cpu_run), 64'd0);
        chk({tag, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
        chk({tag, "_fetch_inst"}, 64'(fetch_inst), 64'h13);
        chk({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
        chk({tag, "_ld_overflow"}, 64'(ld_overflow), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_byte = 8'h00; ld_done = 1'b0;
        load_start = 1'b0; fetch_req = 1'b0; fetch_addr = 64'd0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Two full words, ld_done with the last byte.
        push_wr(64'd0, 32'h0021_1093);
        push_wr(64'd4, 32'h0140_0113);
        bq = '{8'h93, 8'h10, 8'h21, 8'h00, 8'h13, 8'h01, 8'h40, 8'h01};
        stream(1'b1);
        @(negedge clk);
        chk("run_after_load", 64'(cpu_run), 64'd1);
        chk("ready_after_load", 64'(ld_ready), 64'd0);
        @(posedge clk); #1;

        fetch(64'd0, 32'h0021_1093, 1'b0);
        fetch(64'd4, 32'h0140_0113, 1'b0);
        fetch(64'd2, 32'h0000_0013, 1'b1);
        fetch(64'(DEPTH), 32'h0000_0013, 1'b1);
        fetch_req = 1'b0;
        @(posedge clk); #1;

        // load_start with a simultaneous fetch: the fetch is dropped.
        load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 64'd0;
        @(posedge clk); #1;
        load_start = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        chk("run_after_start", 64'(cpu_run), 64'd0);
        chk("ready_after_start", 64'(ld_ready), 64'd1);

        // Partial word flushed with zero fill.
        push_wr(64'd0, 32'h0021_1093);
        push_wr(64'd4, 32'h0000_00AA);
        bq = '{8'h93, 8'h10, 8'h21, 8'h00, 8'hAA};
        stream(1'b1);
        @(negedge clk);
        chk("run_in_flush", 64'(cpu_run), 64'd0);
        @(negedge clk);
        chk("run_after_flush", 64'(cpu_run), 64'd1);
        fetch(64'd4, 32'h0000_00AA, 1'b0);
        fetch_req = 1'b0;

        // Overflow: DEPTH+3 bytes, only in-range words written.
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        bq = {};
        for (int i = 0; i < DEPTH + 3; i++) bq.push_back(8'(8'h30 + i));
        for (int w = 0; w < DEPTH / 4; w++)
            push_wr(64'(4 * w), {8'(8'h33 + 4*w), 8'(8'h32 + 4*w), 8'(8'h31 + 4*w), 8'(8'h30 + 4*w)});
        stream(1'b0);
        chk("ovf_set", 64'(ld_overflow), 64'd1);
        ld_done = 1'b1;
        @(posedge clk); #1;
        ld_done = 1'b0;
        @(negedge clk);
        chk("run_after_ovf", 64'(cpu_run), 64'd1);
        fetch(64'(DEPTH - 4), 32'h3F3E_3D3C, 1'b0);
        fetch(64'(DEPTH), 32'h0000_0013, 1'b1);
        fetch(64'(DEPTH - 3), 32'h0000_0013, 1'b1);
        fetch_req = 1'b0;

        // Reload clears overflow; reset mid-word issues no write.
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 64'(ld_overflow), 64'd0);
        chk("run_reload", 64'(cpu_run), 64'd0);
        bq = '{8'h11, 8'h22};
        stream(1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("fq_drained", 64'(fq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
# imem_load_arbiter

Owns the single port of the byte-addressed instruction memory and shares it between two requesters: the program loader, which streams bytes, and the pipeline fetch stage. After reset it assembles loader bytes into little-endian 32-bit words and writes them. It then releases the processor and serves fetches with one cycle of latency. It sits between the IF stage, the boot/debug byte stream and the instruction memory array.

## Interface
- DEPTH, 128: memory size in bytes; must be a multiple of 4.
- LOAD_ON_RESET, 1: 1 means reset enters S_LOAD; 0 means reset enters S_RUN.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- ld_valid  in  1  loader byte present on ld_byte.
- ld_byte  in  8  loader data byte; stream order is address 0, 1, 2, ….
- ld_ready  out  1  block accepts ld_byte this cycle (transfer = ld_valid & ld_ready).
- ld_done  in  1  end of program stream; sampled only in S_LOAD.
- load_start  in  1  one-cycle pulse; re-enters S_LOAD from S_RUN.
- fetch_req  in  1  IF stage requests an instruction.
- fetch_addr  in  64  byte address of the instruction.
- fetch_valid  out  1  fetch_inst holds the result of the previous cycle's request.
- fetch_inst  out  32  registered instruction.
- fetch_fault  out  1  the returned fetch was misaligned or out of range.
- cpu_run  out  1  high only in S_RUN; the pipeline holds PC at 0 while low.
- ld_overflow  out  1  sticky; a byte arrived beyond DEPTH.
- mem_addr  out  64  word-aligned byte address to the memory.
- mem_we  out  1  word write strobe.
- mem_wdata  out  32  write word; bits [7:0] go to mem_addr+0.
- mem_rdata  in  32  combinational read data for mem_addr.

## Operation
- States:
  - S_LOAD: ld_ready=1. Each transfer places the byte at lane wr_ptr[1:0] of the assembly register and increments wr_ptr. On lane 3, the next cycle drives mem_we=1 with mem_addr=wr_ptr&~3 and the completed word.
  - S_FLUSH: one cycle, entered when ld_done=1 with wr_ptr[1:0]≠0. Writes the partial word with missing lanes filled with 0x00, then goes to S_RUN.
  - S_RUN: fetch service.
- S_LOAD→S_RUN on ld_done with an empty partial word. S_LOAD→S_FLUSH on ld_done with a partial word.
- If ld_done and a transfer occur in the same cycle, the byte is accepted first and then the ld_done rule is applied.
- S_RUN→S_LOAD on load_start. This clears wr_ptr, the assembly register and ld_overflow. Any fetch in that cycle is dropped: fetch_valid=0 in the next cycle.
- Fetch in S_RUN:
  - mem_addr=fetch_addr.
  - The registered result is mem_rdata, or 0x00000013 (NOP) with fetch_fault=1 when fetch_addr[1:0]≠0 or fetch_addr>DEPTH-4.
- Overflow: a transfer with wr_ptr≥DEPTH is accepted and dropped, and sets ld_overflow. wr_ptr saturates; it never wraps.
- Fetch requests outside S_RUN are ignored; the memory is never read during loading.

## Timing
- Reset values:
  - state=S_LOAD (LOAD_ON_RESET=1) or S_RUN (LOAD_ON_RESET=0).
  - wr_ptr=0, ld_ready per state, fetch_valid=0, fetch_inst=0x00000013, fetch_fault=0.
  - cpu_run per state, ld_overflow=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Fetch latency is 1 cycle: a request in cycle t produces fetch_valid/fetch_inst/fetch_fault in cycle t+1. Back-to-back requests give one result per cycle.
- A word write lands 1 cycle after the transfer of its lane-3 byte. mem_we is a one-cycle pulse. Throughput is one byte per cycle with no bubbles.
- cpu_run rises in the cycle after the S_LOAD/S_FLUSH→S_RUN transition, and falls in the cycle after load_start.
- Reset asserted mid-load discards the partial word; no write is issued.

## Structure
- A shared package holds the state encoding (S_LOAD, S_FLUSH, S_RUN), NOP_INST=32'h00000013 and INST_BYTES=4.
- One sub-module, imem_byte_packer, covers lane placement, wr_ptr, partial-word flush and overflow detection. The FSM and the fetch register stay in the top module.

## Test plan
- Reset with LOAD_ON_RESET=1, then stream 8 bytes 93 10 21 00 13 01 40 01 and ld_done → writes 0x00211093 at addr 0 and 0x01400113 at addr 4; cpu_run=1.
- Stream 5 bytes 93 10 21 00 AA, ld_done → S_FLUSH writes 0x000000AA at addr 4; then S_RUN.
- In S_RUN, fetch addr 0 then 4 back-to-back → fetch_valid for 2 cycles with 0x00211093, 0x01400113; fetch_fault=0.
- Fetch addr 2, then addr DEPTH → NOP 0x00000013 with fetch_fault=1 for each.
- Stream DEPTH+3 bytes → ld_overflow=1, the last word write is at DEPTH-4, and no write happens at or above DEPTH.
- load_start together with fetch_req → no fetch_valid, cpu_run=0 next cycle. Reset asserted mid-word → no mem_we, all outputs at reset values.
